// File: rtl/conv_nch_acc_pkg.sv
// Shared types and helpers for the multi-channel convolution accumulator.
// Saturation and ReLU work on a wide signed carrier that callers cast down.
package conv_nch_acc_pkg;

    typedef enum logic [1:0] {
        ACCUM,
        DRAIN,
        HOLD
    } state_t;

    localparam int XW = 128;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic logic signed [XW-1:0] relu(
        input logic signed [XW-1:0] x
    );
        return x[XW-1] ? '0 : x;
    endfunction

    function automatic logic signed [XW-1:0] sat(
        input logic signed [XW-1:0] x,
        input int                   w
    );
        logic signed [XW-1:0] mx;
        logic signed [XW-1:0] mn;
        mx = (XW'(1) << (w - 1)) - XW'(1);
        mn = -mx - XW'(1);
        if (x > mx) return mx;
        if (x < mn) return mn;
        return x;
    endfunction

endpackage

// File: rtl/conv_nch_acc_dot.sv
// KxK signed dot product: registered products, then registered adder-tree sum.
// Tags ride alongside; entry is gated upstream so nothing here ever stalls.
module dot_kxk
    import conv_nch_acc_pkg::*;
#(
    parameter int BIT_WIDTH = 8,
    parameter int K         = 5,
    localparam int NE       = K * K,
    localparam int PW       = 2 * BIT_WIDTH + clog2(K * K)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid,
    input  logic                    first,
    input  logic                    last,
    input  logic [NE*BIT_WIDTH-1:0] px,
    input  logic [NE*BIT_WIDTH-1:0] w,
    output logic                    sum_valid,
    output logic                    sum_first,
    output logic                    sum_last,
    output logic signed [PW-1:0]    sum
);

    localparam int MW = 2 * BIT_WIDTH;

    logic signed [MW-1:0] prod_c [NE];
    logic signed [MW-1:0] prod   [NE];
    logic signed [PW-1:0] sum_c;
    logic                 p_valid;
    logic                 p_first;
    logic                 p_last;

    always_comb begin
        for (int i = 0; i < NE; i++) begin
            prod_c[i] = MW'($signed(px[i*BIT_WIDTH +: BIT_WIDTH]))
                      * MW'($signed(w[i*BIT_WIDTH +: BIT_WIDTH]));
        end
    end

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < NE; i++) begin
            sum_c = sum_c + PW'(prod[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_valid   <= 1'b0;
            sum_valid <= 1'b0;
        end else begin
            p_valid   <= valid;
            sum_valid <= p_valid;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NE; i++) begin
            prod[i] <= prod_c[i];
        end
        p_first   <= first;
        p_last    <= last;
        sum       <= sum_c;
        sum_first <= p_first;
        sum_last  <= p_last;
    end

endmodule

// File: rtl/conv_nch_acc.sv
// Time-multiplexed N-channel KxK convolution: accumulates CHANNELS beats,
// adds scaled bias, optional ReLU, saturates, and holds until taken.
module conv_nch_acc
    import conv_nch_acc_pkg::*;
#(
    parameter int BIT_WIDTH  = 8,
    parameter int OUT_WIDTH  = 32,
    parameter int K          = 5,
    parameter int CHANNELS   = 4,
    parameter int BIAS_SHIFT = 0,
    parameter int RELU       = 1,
    localparam int NE        = K * K,
    localparam int CW        = (clog2(CHANNELS) < 1) ? 1 : clog2(CHANNELS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NE*BIT_WIDTH-1:0] px_in,
    input  logic [NE*BIT_WIDTH-1:0] w_in,
    input  logic [BIT_WIDTH-1:0]    bias,
    output logic [CW-1:0]           ch_idx,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_WIDTH-1:0]    out_data
);

    localparam int PW = 2 * BIT_WIDTH + clog2(K * K);
    localparam int AW = PW + clog2(CHANNELS) + 1;
    localparam int RW = AW + BIAS_SHIFT + 1;
    localparam logic [CW-1:0] LAST_CH = CW'(CHANNELS - 1);

    state_t state;
    state_t state_nx;

    logic                        xfer;
    logic                        first;
    logic                        last;
    logic                        s_valid;
    logic                        s_first;
    logic                        s_last;
    logic signed [PW-1:0]        s_sum;
    logic signed [AW-1:0]        acc;
    logic signed [BIT_WIDTH-1:0] bias_q;
    logic signed [RW-1:0]        base;
    logic signed [RW-1:0]        res;
    logic signed [XW-1:0]        res_x;
    logic signed [XW-1:0]        res_r;
    logic signed [XW-1:0]        res_s;

    assign first = (ch_idx == '0);
    assign last  = (ch_idx == LAST_CH);
    assign xfer  = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= ACCUM;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && last) state_nx = DRAIN;
            end
            DRAIN: begin
                if (s_valid && s_last) state_nx = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = ACCUM;
            end
            default: state_nx = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_idx <= '0;
            bias_q <= '0;
        end else if (xfer) begin
            ch_idx <= last ? '0 : ch_idx + CW'(1);
            if (first) bias_q <= bias;
        end
    end

    dot_kxk #(
        .BIT_WIDTH (BIT_WIDTH),
        .K         (K)
    ) u_dot (
        .clk       (clk),
        .rst       (rst),
        .valid     (xfer),
        .first     (first),
        .last      (last),
        .px        (px_in),
        .w         (w_in),
        .sum_valid (s_valid),
        .sum_first (s_first),
        .sum_last  (s_last),
        .sum       (s_sum)
    );

    // A first-tagged beat starts a fresh group, so stale acc is ignored.
    always_comb begin
        base  = s_first ? '0 : RW'(acc);
        res   = base + RW'(s_sum) + (RW'(bias_q) <<< BIAS_SHIFT);
        res_x = XW'(res);
        res_r = (RELU != 0) ? relu(res_x) : res_x;
        res_s = sat(res_r, OUT_WIDTH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            out_data <= '0;
        end else if (s_valid) begin
            acc <= s_first ? AW'(s_sum) : acc + AW'(s_sum);
            if (s_last) out_data <= OUT_WIDTH'(res_s);
        end
    end

endmodule

// File: tb/tb_conv_nch_acc.sv
// Bench for conv_nch_acc: two instances (default and 16-bit/no-ReLU/shift-4)
// share one stimulus stream; results checked against table and a model.
module tb_conv_nch_acc;

    localparam int BW = 8;
    localparam int NE = 25;
    localparam int CH = 4;
    localparam int N  = NE * BW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [N-1:0]  px_in = '0;
    logic [N-1:0]  w_in = '0;
    logic [BW-1:0] bias = '0;
    logic          in_ready0, in_ready1, ov0, ov1;
    logic [1:0]    ch0, ch1;
    logic [31:0]   od0;
    logic [15:0]   od1;

    int n_chk  = 0;
    int n_fail = 0;

    logic [N-1:0]  gp [CH];
    logic [N-1:0]  gw [CH];
    logic [BW-1:0] gb;

    typedef struct {
        logic [7:0] p;
        logic [7:0] w;
        logic [7:0] b;
        int         gap;
        longint     e0;
        longint     e1;
    } vec_t;

    vec_t tbl [7];

    always #5 clk = ~clk;

    conv_nch_acc u0 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready0),
        .px_in     (px_in),
        .w_in      (w_in),
        .bias      (bias),
        .ch_idx    (ch0),
        .out_valid (ov0),
        .out_ready (out_ready),
        .out_data  (od0)
    );

    conv_nch_acc #(
        .OUT_WIDTH  (16),
        .BIAS_SHIFT (4),
        .RELU       (0)
    ) u1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .px_in     (px_in),
        .w_in      (w_in),
        .bias      (bias),
        .ch_idx    (ch1),
        .out_valid (ov1),
        .out_ready (out_ready),
        .out_data  (od1)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic longint dot(input logic [N-1:0] p, input logic [N-1:0] w);
        longint s;
        s = 0;
        for (int i = 0; i < NE; i++) begin
            s += longint'($signed(p[i*BW +: BW])) * longint'($signed(w[i*BW +: BW]));
        end
        return s;
    endfunction

    function automatic longint model(input longint s, input longint b,
                                     input int sh, input bit relu, input int ow);
        longint v, mx;
        v = s + b * (longint'(1) << sh);
        if (relu && v < 0) v = 0;
        mx = (longint'(1) << (ow - 1)) - 1;
        if (v > mx) v = mx;
        if (v < -mx - 1) v = -mx - 1;
        return v;
    endfunction

    function automatic logic [N-1:0] rnd_vec();
        logic [N-1:0] v;
        for (int j = 0; j < NE; j++) v[j*BW +: BW] = BW'($urandom);
        return v;
    endfunction

    task automatic send(input logic [N-1:0] p, input logic [N-1:0] w,
                        input logic [BW-1:0] b, input int gap, input int c);
        int n;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        px_in    = p;
        w_in     = w;
        bias     = b;
        n = 0;
        while (!in_ready0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready", longint'(in_ready0), 1);
        chk("ch_idx0", longint'(ch0), longint'(c));
        chk("ch_idx1", longint'(ch1), longint'(c));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        bias     = BW'($urandom);
    endtask

    task automatic run_group(input int gap, input int hold,
                             output longint r0, output longint r1);
        longint s, e0, e1;
        int lat;
        s = 0;
        for (int c = 0; c < CH; c++) begin
            send(gp[c], gw[c], (c == 0) ? gb : BW'($urandom), (c == 0) ? 0 : gap, c);
            s += dot(gp[c], gw[c]);
        end
        e0 = model(s, longint'($signed(gb)), 0, 1'b1, 32);
        e1 = model(s, longint'($signed(gb)), 4, 1'b0, 16);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ov0 && lat < 20);
        chk("latency", longint'(lat), 3);
        chk("valid1", longint'(ov1), 1);
        r0 = longint'($signed(od0));
        r1 = longint'($signed(od1));
        chk("data0", r0, e0);
        chk("data1", r1, e1);
        chk("busy_ready", longint'(in_ready0), 0);
        out_ready = (hold == 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", longint'(ov0), 1);
            chk("hold_data", longint'($signed(od0)), e0);
            chk("hold_ready", longint'(in_ready0), 0);
            if (h == hold - 1) out_ready = 1'b1;
        end
        @(negedge clk);
        chk("post_valid", longint'(ov0), 0);
        chk("post_ready", longint'(in_ready0), 1);
        chk("post_ch", longint'(ch0), 0);
        out_ready = 1'b0;
    endtask

    task automatic fill_uniform(input logic [7:0] p, input logic [7:0] w, input logic [7:0] b);
        for (int c = 0; c < CH; c++) begin
            gp[c] = {NE{p}};
            gw[c] = {NE{w}};
        end
        gb = b;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        longint r0, r1;

        tbl[0] = '{8'h01, 8'h01, 8'h03, 0, 103, 148};
        tbl[1] = '{8'h01, 8'hff, 8'h00, 0, 0, -100};
        tbl[2] = '{8'h80, 8'h80, 8'h00, 0, 1638400, 32767};
        tbl[3] = '{8'h80, 8'h7f, 8'h00, 0, 0, -32768};
        tbl[4] = '{8'h00, 8'h5a, 8'hfe, 2, 0, -32};
        tbl[5] = '{8'h7f, 8'h7f, 8'h7f, 1, 1613027, 32767};
        tbl[6] = '{8'h02, 8'hfd, 8'h64, 0, 0, 1000};

        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", longint'(in_ready0), 1);
        chk("rst_out_valid", longint'(ov0), 0);
        chk("rst_out_data", longint'(od0), 0);
        chk("rst_ch_idx", longint'(ch0), 0);
        chk("rst_out_data1", longint'(od1), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            fill_uniform(tbl[i].p, tbl[i].w, tbl[i].b);
            run_group(tbl[i].gap, 0, r0, r1);
            chk("tbl_e0", r0, tbl[i].e0);
            chk("tbl_e1", r1, tbl[i].e1);
        end

        fill_uniform(8'h01, 8'h01, 8'h03);
        run_group(0, 5, r0, r1);
        chk("stall_e0", r0, 103);

        send(gp[0], gw[0], 8'h50, 0, 0);
        send(gp[1], gw[1], 8'h50, 0, 1);
        rst      = 1'b1;
        in_valid = 1'b1;
        px_in    = gp[0];
        w_in     = gw[0];
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("abort_ch_idx", longint'(ch0), 0);
        chk("abort_in_ready", longint'(in_ready0), 1);
        chk("abort_out_valid", longint'(ov0), 0);
        run_group(0, 0, r0, r1);
        chk("abort_e0", r0, 103);
        chk("abort_e1", r1, 148);

        for (int g = 0; g < 20; g++) begin
            for (int c = 0; c < CH; c++) begin
                gp[c] = rnd_vec();
                gw[c] = rnd_vec();
            end
            gb = BW'($urandom);
            run_group(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), r0, r1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
